regfile_debug_responder: RTL and testbench
==========================================

Name: regfile_debug_responder

Overview:
- 32x32 RISC-V register file serving two ports: the processor-side read/write port and a debug request/response port driven by an external initiator, for example a UART debug bridge.
- The core port keeps the existing regfile timing: synchronous read, write-through forwarding, and x0 hard-wired to zero.
- The debug port uses valid/ready handshakes and a small FSM. It steals the write port only in cycles when the core does not write.

Parameters:
- NUM_REGS, 32, number of registers; must be a power of 2.
- DATA_W, 32, register width in bits.
- ADDR_W, $clog2(NUM_REGS), register address width.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- readReg1  in  ADDR_W  core read address A.
- readReg2  in  ADDR_W  core read address B.
- writeReg  in  ADDR_W  core write address.
- writeData  in  DATA_W  core write data.
- write  in  1  core write enable.
- readData1  out  DATA_W  registered read data A.
- readData2  out  DATA_W  registered read data B.
- dbg_req_valid  in  1  debug request valid.
- dbg_req_ready  out  1  debug request accepted when high together with dbg_req_valid.
- dbg_req_we  in  1  1 = write request, 0 = read request.
- dbg_req_addr  in  ADDR_W  debug register address.
- dbg_req_wdata  in  DATA_W  debug write data.
- dbg_rsp_valid  out  1  debug response valid.
- dbg_rsp_ready  in  1  initiator accepts the response.
- dbg_rsp_rdata  out  DATA_W  read data; 0 for write responses.
- dbg_busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All registers cleared to 0.
  - readData1 and readData2 = 0.
  - FSM goes to IDLE.
  - dbg_rsp_valid = 0, dbg_rsp_rdata = 0, dbg_req_ready = 0 while reset is asserted.
  - A transaction in flight when reset asserts is dropped; no response is issued.
- Core reads:
  - readDataN <= reg[readRegN] at each posedge, so data appears one cycle after the address.
  - If a write to the same nonzero address commits in that cycle (core or debug), readDataN <= the new write data.
  - Address 0 always returns 0.
- Core writes:
  - When write=1 and writeReg!=0, reg[writeReg] <= writeData at posedge.
  - Writes to x0 are ignored.
- FSM states are IDLE, ACCESS and RESP.
- IDLE:
  - dbg_req_ready = 1.
  - On dbg_req_valid, latch we, addr and wdata, then go to ACCESS.
- ACCESS:
  - For a write, the write commits only when core write=0. Otherwise stay in ACCESS; the core has absolute priority.
  - A debug write to addr 0 completes without modifying state.
  - For a read, capture reg[addr] in the first ACCESS cycle. Forward core writeData if the core writes the same nonzero address that cycle.
  - After the access completes, go to RESP.
- RESP:
  - dbg_rsp_valid = 1; dbg_rsp_rdata is held stable.
  - Go to IDLE on dbg_rsp_ready.
  - dbg_req_ready = 0 here, so the next request is accepted at the earliest in the cycle after returning to IDLE.
- Minimum transaction is 3 cycles (accept, access, response). Write stall cycles are unbounded while the core keeps writing.
- dbg_rsp_valid and dbg_rsp_rdata are registered; no combinational path from dbg inputs to dbg outputs except dbg_req_ready, which decodes the FSM state only.

Decomposition:
- Package regfile_pkg holds:
  - NUM_REGS, DATA_W and ADDR_W defaults.
  - typedef dbg_state_t, an enum {IDLE, ACCESS, RESP}.
  - typedef reg_addr_t and reg_data_t.
- One sub-module, regfile_core: storage array plus the two synchronous read ports with forwarding, and a single arbitrated write port.
- The top level holds the debug FSM and the write-port mux.

Test Plan:
- Reset check: pulse rst_n low mid-simulation, asynchronously between clock edges. Required immediately: readData1/2=0, dbg_rsp_valid=0. After release, reads of addresses 1..31 return 0.
- Core write-through: write=1, writeReg=5, writeData=32'hDEADBEEF, with readReg1=5 and readReg2=0. Required next cycle: readData1=32'hDEADBEEF and readData2=0.
- Debug write then core read: debug request we=1, addr=7, wdata=32'h01020304 with core write=0. Required: dbg_rsp_valid 2 cycles after acceptance with rdata=0, and a subsequent core read of x7 returns 32'h01020304.
- Debug write stall: hold core write=1 to x3 for 4 cycles during a debug write to x9. Required: dbg_busy stays high, the debug write commits in the first cycle with write=0, and x3 holds the last core data.
- Debug read with collision and backpressure: debug read of x0 returns 0. Debug read of x12 while the core writes 32'hCAFEF00D to x12 in the ACCESS cycle returns 32'hCAFEF00D. Hold dbg_rsp_ready=0 for 5 cycles: rsp_valid and rdata stay stable and no new request is accepted.
- Random: 300 mixed core and debug transactions checked against a behavioural model. No X on readData1/2 or dbg_rsp_rdata after reset.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared sizes, debug FSM state and register types for the regfile
package regfile_pkg;
  localparam int NUM_REGS = 32;
  localparam int DATA_W = 32;
  localparam int ADDR_W = $clog2(NUM_REGS);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} dbg_state_t;
  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;
endpackage

// File: rtl/regfile_core.sv
// regfile_core: register storage, two registered read ports with write forwarding, one write port
module regfile_core #(
  parameter int NUM_REGS = regfile_pkg::NUM_REGS,
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  input  logic [ADDR_W-1:0] dbg_raddr,
  output logic [DATA_W-1:0] dbg_rdata,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata
);
  logic [DATA_W-1:0] mem [NUM_REGS];
  logic wr;
  assign wr = we && waddr != '0;
  assign dbg_rdata = mem[dbg_raddr];
  // storage update and registered reads; x0 never written so it stays zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
      rdata1 <= '0;
      rdata2 <= '0;
    end else begin
      if (wr) mem[waddr] <= wdata;
      rdata1 <= raddr1 == '0 ? '0 : (wr && waddr == raddr1) ? wdata : mem[raddr1];
      rdata2 <= raddr2 == '0 ? '0 : (wr && waddr == raddr2) ? wdata : mem[raddr2];
    end
  end
endmodule

// File: rtl/regfile_debug_responder.sv
// regfile_debug_responder: core regfile plus a debug request/response port that borrows idle write cycles
module regfile_debug_responder #(
  parameter int NUM_REGS = regfile_pkg::NUM_REGS,
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] readReg1,
  input  logic [ADDR_W-1:0] readReg2,
  input  logic [ADDR_W-1:0] writeReg,
  input  logic [DATA_W-1:0] writeData,
  input  logic              write,
  output logic [DATA_W-1:0] readData1,
  output logic [DATA_W-1:0] readData2,
  input  logic              dbg_req_valid,
  output logic              dbg_req_ready,
  input  logic              dbg_req_we,
  input  logic [ADDR_W-1:0] dbg_req_addr,
  input  logic [DATA_W-1:0] dbg_req_wdata,
  output logic              dbg_rsp_valid,
  input  logic              dbg_rsp_ready,
  output logic [DATA_W-1:0] dbg_rsp_rdata,
  output logic              dbg_busy
);
  import regfile_pkg::*;
  dbg_state_t state;
  logic we_q, dbg_commit, core_fwd;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, dbg_rdata;
  assign dbg_commit = state == ACCESS && we_q && !write;
  assign core_fwd = write && writeReg == addr_q && addr_q != '0;
  assign dbg_req_ready = rst_n && state == IDLE;
  assign dbg_busy = state != IDLE;
  regfile_core #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_core (
    .clk(clk),
    .rst_n(rst_n),
    .raddr1(readReg1),
    .raddr2(readReg2),
    .rdata1(readData1),
    .rdata2(readData2),
    .dbg_raddr(addr_q),
    .dbg_rdata(dbg_rdata),
    .we(write || dbg_commit),
    .waddr(write ? writeReg : addr_q),
    .wdata(write ? writeData : wdata_q)
  );
  // debug FSM: accept, access (writes wait for a free write port), hold response until taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      dbg_rsp_valid <= 1'b0;
      dbg_rsp_rdata <= '0;
    end else begin
      case (state)
        IDLE: if (dbg_req_valid) begin
          we_q <= dbg_req_we;
          addr_q <= dbg_req_addr;
          wdata_q <= dbg_req_wdata;
          state <= ACCESS;
        end
        ACCESS: if (!we_q || !write) begin
          dbg_rsp_valid <= 1'b1;
          dbg_rsp_rdata <= we_q ? '0 : core_fwd ? writeData : dbg_rdata;
          state <= RESP;
        end
        RESP: if (dbg_rsp_ready) begin
          dbg_rsp_valid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_regfile_debug_responder.sv
// tb_regfile_debug_responder: directed and model-checked stimulus for the debug-port regfile
module tb_regfile_debug_responder;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [4:0] readReg1 = '0, readReg2 = '0, writeReg = '0, dbg_req_addr = '0;
  logic [31:0] writeData = '0, dbg_req_wdata = '0, readData1, readData2, dbg_rsp_rdata;
  logic write = 1'b0, dbg_req_valid = 1'b0, dbg_req_we = 1'b0, dbg_rsp_ready = 1'b0;
  logic dbg_req_ready, dbg_rsp_valid, dbg_busy;
  logic [31:0] m [32];
  int checks = 0, failures = 0;

  regfile_debug_responder dut (
    .clk(clk), .rst_n(rst_n),
    .readReg1(readReg1), .readReg2(readReg2), .writeReg(writeReg), .writeData(writeData), .write(write),
    .readData1(readData1), .readData2(readData2),
    .dbg_req_valid(dbg_req_valid), .dbg_req_ready(dbg_req_ready), .dbg_req_we(dbg_req_we),
    .dbg_req_addr(dbg_req_addr), .dbg_req_wdata(dbg_req_wdata),
    .dbg_rsp_valid(dbg_rsp_valid), .dbg_rsp_ready(dbg_rsp_ready), .dbg_rsp_rdata(dbg_rsp_rdata),
    .dbg_busy(dbg_busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic core_cycle(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                            input logic [4:0] r1, input logic [4:0] r2);
    logic [31:0] e1, e2;
    e1 = r1 == 0 ? 32'h0 : (we && wa == r1) ? wd : m[r1];
    e2 = r2 == 0 ? 32'h0 : (we && wa == r2) ? wd : m[r2];
    write = we; writeReg = wa; writeData = wd; readReg1 = r1; readReg2 = r2;
    tick();
    if (we && wa != 0) m[wa] = wd;
    write = 1'b0;
    chk("core_rd1", readData1, e1);
    chk("core_rd2", readData2, e2);
  endtask

  task automatic dbg_txn(input logic we, input logic [4:0] a, input logic [31:0] wd);
    logic [31:0] exp;
    exp = we ? 32'h0 : m[a];
    write = 1'b0;
    chk("dbg_ready_idle", {31'h0, dbg_req_ready}, 32'h1);
    dbg_req_valid = 1'b1; dbg_req_we = we; dbg_req_addr = a; dbg_req_wdata = wd;
    tick();
    dbg_req_valid = 1'b0;
    chk("dbg_busy_access", {31'h0, dbg_busy}, 32'h1);
    chk("dbg_rsp_early", {31'h0, dbg_rsp_valid}, 32'h0);
    tick();
    if (we && a != 0) m[a] = wd;
    chk("dbg_rsp_valid", {31'h0, dbg_rsp_valid}, 32'h1);
    chk("dbg_rsp_rdata", dbg_rsp_rdata, exp);
    dbg_rsp_ready = 1'b1;
    tick();
    dbg_rsp_ready = 1'b0;
    chk("dbg_rsp_done", {31'h0, dbg_rsp_valid}, 32'h0);
    chk("dbg_idle", {31'h0, dbg_busy}, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m[i] = '0;
    #12;
    chk("rst_rd1", readData1, 32'h0);
    chk("rst_rsp_valid", {31'h0, dbg_rsp_valid}, 32'h0);
    chk("rst_ready", {31'h0, dbg_req_ready}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    core_cycle(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0);
    core_cycle(1'b1, 5'd0, 32'h12345678, 5'd0, 5'd5);
    dbg_txn(1'b1, 5'd7, 32'h01020304);
    core_cycle(1'b0, 5'd0, 32'h0, 5'd7, 5'd5);
    // debug write to x9 stalled by four core writes to x3
    write = 1'b1; writeReg = 5'd3; writeData = 32'hA0A0A000; readReg1 = 5'd9; readReg2 = 5'd3;
    dbg_req_valid = 1'b1; dbg_req_we = 1'b1; dbg_req_addr = 5'd9; dbg_req_wdata = 32'h99990009;
    tick();
    m[3] = 32'hA0A0A000;
    dbg_req_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      writeData = 32'hA0A0A000 + k;
      tick();
      m[3] = writeData;
      chk("stall_busy", {31'h0, dbg_busy}, 32'h1);
      chk("stall_no_rsp", {31'h0, dbg_rsp_valid}, 32'h0);
      chk("stall_x9_old", readData1, 32'h0);
    end
    write = 1'b0;
    tick();
    m[9] = 32'h99990009;
    chk("stall_commit_fwd", readData1, 32'h99990009);
    chk("stall_x3_last", readData2, 32'hA0A0A004);
    chk("stall_rsp_valid", {31'h0, dbg_rsp_valid}, 32'h1);
    chk("stall_rsp_rdata", dbg_rsp_rdata, 32'h0);
    dbg_rsp_ready = 1'b1;
    tick();
    dbg_rsp_ready = 1'b0;
    core_cycle(1'b0, 5'd0, 32'h0, 5'd9, 5'd3);
    dbg_txn(1'b0, 5'd0, 32'h0);
    // debug read of x12 colliding with a core write in the access cycle
    dbg_req_valid = 1'b1; dbg_req_we = 1'b0; dbg_req_addr = 5'd12;
    tick();
    dbg_req_valid = 1'b0;
    write = 1'b1; writeReg = 5'd12; writeData = 32'hCAFEF00D;
    tick();
    m[12] = 32'hCAFEF00D;
    write = 1'b0;
    chk("coll_rsp_valid", {31'h0, dbg_rsp_valid}, 32'h1);
    chk("coll_rsp_rdata", dbg_rsp_rdata, 32'hCAFEF00D);
    dbg_req_valid = 1'b1; dbg_req_we = 1'b1; dbg_req_addr = 5'd4; dbg_req_wdata = 32'h55;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_rsp_valid", {31'h0, dbg_rsp_valid}, 32'h1);
      chk("bp_rsp_rdata", dbg_rsp_rdata, 32'hCAFEF00D);
      chk("bp_not_ready", {31'h0, dbg_req_ready}, 32'h0);
    end
    dbg_req_valid = 1'b0;
    dbg_rsp_ready = 1'b1;
    tick();
    dbg_rsp_ready = 1'b0;
    chk("bp_released", {31'h0, dbg_rsp_valid}, 32'h0);
    chk("bp_idle_ready", {31'h0, dbg_req_ready}, 32'h1);
    core_cycle(1'b0, 5'd0, 32'h0, 5'd4, 5'd12);
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0)
        dbg_txn(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
      else
        core_cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                   5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    end
    // asynchronous reset in the middle of a pending response
    dbg_req_valid = 1'b1; dbg_req_we = 1'b0; dbg_req_addr = 5'd5;
    tick();
    dbg_req_valid = 1'b0;
    readReg1 = 5'd5; readReg2 = 5'd9;
    tick();
    chk("pre_rst_rsp", {31'h0, dbg_rsp_valid}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rd1", readData1, 32'h0);
    chk("arst_rd2", readData2, 32'h0);
    chk("arst_rsp_valid", {31'h0, dbg_rsp_valid}, 32'h0);
    chk("arst_rsp_rdata", dbg_rsp_rdata, 32'h0);
    chk("arst_ready", {31'h0, dbg_req_ready}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) m[i] = '0;
    chk("post_rst_idle", {31'h0, dbg_busy}, 32'h0);
    for (int i = 1; i < 32; i++) core_cycle(1'b0, 5'd0, 32'h0, 5'(i), 5'(32 - i));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
